// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e    : operation code driven by the core's control block on `op`.
//   state_e : sequencer states of muldiv_unit.
//   op_is_div / op_is_signed : small decode helpers used by the sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration of the multiply/divide datapath.
// Purely combinational; the sequencer registers acc/mq every cycle.
//   is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc    : multiply: running upper half of the product
//            divide  : partial remainder
//   mq     : multiply: multiplier, shifted out LSB first, product low bits in
//            divide  : dividend, shifted out MSB first, quotient bits in
//   opnd   : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_n, mq_n : values after this iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] mq_n
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift {carry, acc, mq} right by one. After WIDTH steps
        // {acc, mq} holds the full 2*WIDTH product.
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        // Divide: bring the next dividend bit into the remainder and try
        // subtracting the divisor. Bit WIDTH of diff is the borrow, since the
        // shifted remainder is always below twice the divisor.
        shifted = {acc, mq[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};

        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_n = diff[WIDTH-1:0];
                mq_n  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted[WIDTH-1:0];
                mq_n  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = sum[WIDTH:1];
            mq_n  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU/DIV/DIVU run for WIDTH+2 cycles (IDLE->CALC x WIDTH->FIX);
// MTHI/MTLO write HI/LO directly from IDLE in a single cycle.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   start, op, a, b   : request, operation code (muldiv_pkg::op_e), operands
//   cancel            : abort the in-flight operation, HI/LO untouched
//   busy              : high in CALC and FIX; start is ignored while high
//   done              : one-cycle pulse after HI/LO were written by mul/div
//   div_zero          : pulses with done when the divisor was zero
//   hi_data, lo_data  : architectural HI and LO registers
// Handshake: a request is taken on a rising edge where start=1, busy=0 and
// cancel=0; it is never queued. done/div_zero are registered pulses that
// appear in the first IDLE cycle, so a new start is accepted during done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;   // negate product / quotient
    logic             neg_hi_q, neg_hi_d;   // negate remainder
    logic             bzero_q, bzero_d;     // divisor was zero
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_mq;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               a_neg;
    logic               b_neg;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div (is_div_q),
        .acc    (acc_q),
        .mq     (mq_q),
        .opnd   (opnd_q),
        .acc_n  (step_acc),
        .mq_n   (step_mq)
    );

    always_comb begin
        // Operand magnitudes; unsigned ops pass straight through.
        a_neg = op_is_signed(op) && a[WIDTH-1];
        b_neg = op_is_signed(op) && b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;

        // Sign correction of the finished unsigned result. Negating the MIN
        // magnitude yields MIN again, which gives MIN / -1 = MIN, rem 0.
        prod_raw = {acc_q, mq_q};
        prod_fix = neg_lo_q ? -prod_raw : prod_raw;
        quo_fix  = neg_lo_q ? -mq_q : mq_q;
        rem_fix  = neg_hi_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        bzero_d    = bzero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d  = ST_CALC;
                            cnt_d    = '0;
                            acc_d    = '0;
                            mq_d     = a_mag;
                            opnd_d   = b_mag;
                            is_div_d = op_is_div(op);
                            neg_lo_d = a_neg ^ b_neg;
                            // Remainder takes the dividend's sign; for a
                            // multiply only neg_lo is used.
                            neg_hi_d = a_neg;
                            bzero_d  = (b == '0);
                        end
                        default: ;
                    endcase
                end
            end

            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    mq_d  = step_mq;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_FIX;
                    end
                end
            end

            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // With a zero divisor every trial subtract succeeds,
                        // so the remainder ends up as the dividend itself
                        // (hi = a after sign fix); only lo needs forcing.
                        hi_d       = rem_fix;
                        lo_d       = bzero_q ? '1 : quo_fix;
                        div_zero_d = bzero_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            bzero_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            bzero_q    <= bzero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_data  = hi_q;
    assign lo_data  = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_data;
    logic [W-1:0] lo_data;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    int busy_cycles;

    // Scoreboard: {div_zero, hi, lo} plus the edge on which done must show.
    logic [2*W:0] exp_q[$];
    int           exp_edge_q[$];

    // Model copy of the architectural registers.
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_data  (hi_data),
        .lo_data  (lo_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint       sx, sy, q, r;
        logic [63:0]  p;
        logic [W-1:0] hi, lo;
        logic         dz;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (o)
            OP_MULT: begin
                p  = 64'(sx * sy);
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'd0, x} * {32'd0, y};
                hi = p[63:32];
                lo = p[31:0];
            end
            OP_DIV: begin
                if (y == '0) begin
                    dz = 1'b1; hi = x; lo = '1;
                end else begin
                    q  = sx / sy;
                    r  = sx % sy;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            default: begin // OP_DIVU
                if (y == '0) begin
                    dz = 1'b1; hi = x; lo = '1;
                end else begin
                    lo = x / y;
                    hi = x % y;
                end
            end
        endcase
        return {dz, hi, lo};
    endfunction

    // ---------------- driver tasks ----------------
    // Drives a request, lets one rising edge sample it. When expect_result
    // is set the model result is pushed to the scoreboard.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit expect_result);
        logic [2*W:0] r;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OP_NOP;
        if (expect_result) begin
            r = model(o, x, y);
            exp_q.push_back(r);
            exp_edge_q.push_back(cycle_cnt + W + 1);
            m_hi = r[2*W-1:W];
            m_lo = r[W-1:0];
        end
    endtask

    // Waits (bounded) until done is seen at a falling edge; counts busy cycles.
    task automatic wait_done();
        int n;
        busy_cycles = 0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cycles++;
            n++;
        end
        if (n >= 100) check("done_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [2*W:0] e;
        int           edge_n;
        if (!rst) begin
            if (div_zero && !done) check("div_zero_without_done", 64'd1, 64'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e      = exp_q.pop_front();
                    edge_n = exp_edge_q.pop_front();
                    check("hi", 64'(hi_data), 64'(e[2*W-1:W]));
                    check("lo", 64'(lo_data), 64'(e[W-1:0]));
                    check("div_zero", 64'(div_zero), 64'(e[2*W]));
                    check("latency_edge", 64'(cycle_cnt), 64'(edge_n));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0; cancel = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", 64'(hi_data), 64'd0);
        check("reset_lo", 64'(lo_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div_zero", 64'(div_zero), 64'd0);

        // Full-range unsigned multiply, busy length and done width.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        check("multu_busy_cycles", 64'(busy_cycles), 64'(W + 1));
        check("multu_hi_literal", 64'(hi_data), 64'hFFFF_FFFE);
        check("multu_lo_literal", 64'(lo_data), 64'h0000_0001);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);

        // Signed multiply, then DIV issued back-to-back in the done cycle.
        issue(OP_MULT, -32'sd3, 32'sd5, 1'b1);
        wait_done();
        check("mult_hi_literal", 64'(hi_data), 64'hFFFF_FFFF);
        check("mult_lo_literal", 64'(lo_data), 64'hFFFF_FFF1);
        issue(OP_DIV, -32'sd7, 32'sd2, 1'b1);
        check("b2b_accepted_busy", 64'(busy), 64'd1);
        wait_done();
        check("div_lo_literal", 64'(lo_data), 64'hFFFF_FFFD);
        check("div_hi_literal", 64'(hi_data), 64'hFFFF_FFFF);

        // Signed overflow: MIN / -1.
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        check("ovf_lo_literal", 64'(lo_data), 64'h8000_0000);
        check("ovf_hi_literal", 64'(hi_data), 64'd0);

        // Divide by zero.
        issue(OP_DIVU, 32'd100, 32'd0, 1'b1);
        wait_done();
        check("dz_flag_with_done", 64'(div_zero), 64'd1);
        @(negedge clk);
        check("dz_flag_one_cycle", 64'(div_zero), 64'd0);

        // MTHI in IDLE: hi updates on the sampling edge, no busy/done.
        issue(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        m_hi = 32'h1234_5678;
        check("mthi_hi", 64'(hi_data), 64'(m_hi));
        check("mthi_no_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("mthi_no_done", 64'(done), 64'd0);

        // MTLO while busy is dropped; MULTU completes normally.
        issue(OP_MULTU, 32'd7, 32'd9, 1'b1);
        issue(OP_MTLO, 32'h1234_5678, 32'd0, 1'b0);
        check("mtlo_busy_ignored", 64'(lo_data), 64'hFFFF_FFFF);
        issue(OP_MULT, 32'd3, 32'd3, 1'b0);   // also dropped
        wait_done();

        // Cancel at edge 10 of a MULTU.
        issue(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        repeat (8) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("cancel_hi_kept", 64'(hi_data), 64'(m_hi));
        check("cancel_lo_kept", 64'(lo_data), 64'(m_lo));

        // Cancel together with start in IDLE: start dropped.
        cancel = 1'b1;
        issue(OP_MULTU, 32'd5, 32'd5, 1'b0);
        cancel = 1'b0;
        check("cancel_start_idle", 64'(busy), 64'd0);

        // Random mul/div, issued back-to-back in the done cycle.
        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom();
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom();
            endcase
            issue(ro, ra, rb, 1'b1);
            wait_done();
        end

        // Asynchronous reset mid-CALC.
        issue(OP_MULTU, 32'h0F0F_0F0F, 32'h3333_3333, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_hi", 64'(hi_data), 64'd0);
        check("async_rst_lo", 64'(lo_data), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(busy), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit owning the architectural HI/LO registers. It replaces the HI/LO handling in the single-cycle ALU. It executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake, plus single-cycle MTHI/MTLO. The core's control stalls dependent MFHI/MFLO while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width (>=4, even)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous and active-high
start  in  1  request; sampled on the rising edge of clk
op  in  3  operation code (package encoding)
a  in  WIDTH  operand A (rs): multiplicand / dividend / MTHI/MTLO source
b  in  WIDTH  operand B (rt): multiplier / divisor
cancel  in  1  abort the in-flight operation
busy  out  1  operation in progress; start ignored
done  out  1  one-cycle pulse; HI/LO just updated by mul/div
div_zero  out  1  one-cycle pulse with done when the divisor was 0
hi_data  out  WIDTH  HI register
lo_data  out  WIDTH  LO register

Behaviour:
- Reset (async, rst=1): state IDLE; hi_data=0, lo_data=0, busy=0, done=0, div_zero=0; counter and operand registers cleared. Reset mid-operation discards the result.
- States: IDLE, CALC, FIX.
- IDLE: start=1 with op=MTHI -> hi_data<=a next edge, no busy/done. op=MTLO -> lo_data<=a. op=NOP or undefined -> no effect. op in {MULT,MULTU,DIV,DIVU} -> latch a, b, op; signed ops latch magnitudes and record result signs; counter<=0; ->CALC.
- CALC: one radix-2 step per cycle (shift-add multiply; restoring divide). Counter increments. When the counter reaches WIDTH-1 that edge -> FIX, so CALC lasts exactly WIDTH cycles.
- FIX: apply sign correction, write HI/LO, assert done (and div_zero if applicable) for the following cycle, ->IDLE.
- Latency: counting the start-sampling edge as edge 1, HI/LO are updated on edge WIDTH+2; done=1 during the cycle after (34 edges for WIDTH=32).
- busy=1 in CALC and FIX; busy=0 in the done cycle, so back-to-back start is accepted in the done cycle.
- start while busy is ignored: no queueing, operands dropped. This includes MTHI/MTLO.
- cancel=1 while busy -> IDLE next edge; HI/LO unchanged; no done. cancel in IDLE has no effect. cancel and start together in IDLE: cancel wins, start is dropped.
- Multiply: {hi,lo} = full 2*WIDTH product. MULT is signed two's-complement; MULTU is unsigned.
- Divide: lo=quotient, hi=remainder. Signed division truncates toward zero; remainder sign equals dividend sign.
- Divide by zero: hi=a, lo=all ones, div_zero=1 with done. Still takes full latency.
- Signed overflow (DIV of MIN by -1): lo=MIN, hi=0, no flag.
- HI/LO hold their value at all times except on a FIX edge or an MTHI/MTLO edge.

Decomposition:
- Package muldiv_pkg: op encoding NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; state enum (IDLE/CALC/FIX).
- The ctrl block includes muldiv_pkg to drive op.
- One natural sub-module: muldiv_step, the combinational single-iteration datapath (add/shift or trial subtract). The FSM, counter and sign fix stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy high 33 cycles.
- MULT a=-3 b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. Back-to-back DIV started in the done cycle is accepted.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100 b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_zero and done high together for one cycle.
- MTHI a=0x12345678 in IDLE -> hi updates next edge, no done. Same MTLO issued while busy -> ignored, lo unchanged.
- Start MULTU, then cancel at edge 10 -> IDLE, HI/LO keep prior values, no done. Separately, assert rst asynchronously mid-CALC -> all outputs 0 immediately.
